// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl - control sequencer for the stopwatch datapath.
// Synchronizes, debounces and edge-detects three push-buttons, then runs the
// IDLE/RUN/PAUSE/LAP machine that gates the 100 Hz count tick, pulses the
// counter clear and freezes the display during lap hold.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous active-high reset
//   btn_startstop  raw asynchronous button, high = pressed
//   btn_lap        raw asynchronous button, high = pressed
//   btn_reset      raw asynchronous button, high = pressed
//   tick           one-cycle count enable, only in RUN or LAP
//   clear          one-cycle pulse zeroing the time counter
//   freeze         high while in LAP (display latch holds)
//   state          IDLE=0, RUN=1, PAUSE=2, LAP=3
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | stopped at zero, prescaler held at 0
// RUN    | counting, ticks issued every TICK_DIV cycles
// PAUSE  | stopped, prescaler keeps its fractional count
// LAP    | counting continues, display frozen

module stopwatch_ctrl #(
   parameter int TICK_DIV        = 1000000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_startstop,
   input  logic       btn_lap,
   input  logic       btn_reset,
   output logic       tick,
   output logic       clear,
   output logic       freeze,
   output logic [1:0] state
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam int B_SS  = 0;
   localparam int B_LAP = 1;
   localparam int B_RST = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   logic [2:0]       btn_raw;
   logic [2:0]       sync1_q, sync1_d;
   logic [2:0]       sync2_q, sync2_d;
   logic [2:0]       lvl_q, lvl_d;
   logic [2:0]       lvl_prev_q, lvl_prev_d;
   logic [2:0]       press;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             clear_q, clear_d;
   logic             freeze_q, freeze_d;
   logic             is_run_cur, is_run_nxt;

   assign btn_raw = {btn_reset, btn_lap, btn_startstop};

   // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
   // consecutive differing samples; any matching sample restarts the count.
   always_comb begin
      sync1_d    = btn_raw;
      sync2_d    = sync1_q;
      lvl_prev_d = lvl_q;
      lvl_d      = lvl_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            lvl_d[i] = ~lvl_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign press = lvl_q & ~lvl_prev_q;

   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      if (press[B_RST]) begin
         state_d = ST_IDLE;
         clear_d = 1'b1;
      end else if (press[B_SS]) begin
         case (state_q)
            ST_RUN, ST_LAP: state_d = ST_PAUSE;
            default:        state_d = ST_RUN;
         endcase
      end else if (press[B_LAP]) begin
         case (state_q)
            ST_RUN:  state_d = ST_LAP;
            ST_LAP:  state_d = ST_RUN;
            default: state_d = state_q;
         endcase
      end

      is_run_cur = (state_q == ST_RUN) || (state_q == ST_LAP);
      is_run_nxt = (state_d == ST_RUN) || (state_d == ST_LAP);
      freeze_d   = (state_d == ST_LAP);

      // Prescaler only advances while running on both sides of the edge, so
      // a stop coinciding with the terminal count holds it there and the
      // pending tick is delivered right after resume instead of being lost.
      tick_d = 1'b0;
      div_d  = div_q;
      if (state_d == ST_IDLE) begin
         div_d = '0;
      end else if (is_run_cur && is_run_nxt) begin
         if (div_q == DIV_MAX) begin
            div_d  = '0;
            tick_d = 1'b1;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         lvl_q      <= '0;
         lvl_prev_q <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
         state_q    <= ST_IDLE;
         div_q      <= '0;
         tick_q     <= 1'b0;
         clear_q    <= 1'b0;
         freeze_q   <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         lvl_q      <= lvl_d;
         lvl_prev_q <= lvl_prev_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         state_q    <= state_d;
         div_q      <= div_d;
         tick_q     <= tick_d;
         clear_q    <= clear_d;
         freeze_q   <= freeze_d;
      end
   end

   assign tick   = tick_q;
   assign clear  = clear_q;
   assign freeze = freeze_q;
   assign state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl - bench for stopwatch_ctrl with TICK_DIV=10 and
// DEBOUNCE_CYCLES=4: directed scenarios with hand-derived latencies, then a
// randomized button phase, all outputs compared every cycle against a
// behavioural model of the stopwatch.

module tb_stopwatch_ctrl;

   localparam int TD = 10;
   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_startstop;
   logic       btn_lap;
   logic       btn_reset;
   logic       tick;
   logic       clear;
   logic       freeze;
   logic [1:0] state;

   int n_chk = 0;
   int n_err = 0;

   stopwatch_ctrl #(
      .TICK_DIV        (TD),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_startstop (btn_startstop),
      .btn_lap       (btn_lap),
      .btn_reset     (btn_reset),
      .tick          (tick),
      .clear         (clear),
      .freeze        (freeze),
      .state         (state)
   );

   always #5 clk = ~clk;

   // Reference model. Index 0 = startstop, 1 = lap, 2 = reset button.
   // m_run counts how many consecutive synchronized samples disagree with
   // the accepted level; reaching DB accepts the new level. Events accepted
   // on one edge act on the machine at the following edge.
   bit m_p1 [3];
   bit m_p2 [3];
   bit m_acc[3];
   bit m_ev [3];
   int m_run[3];
   int m_state;
   int m_elapsed;
   bit m_tick, m_clear, m_freeze;

   always @(posedge clk) begin : model
      bit raw[3];
      bit samp;
      int nxt;
      bit running_now, running_next;
      raw[0] = btn_startstop;
      raw[1] = btn_lap;
      raw[2] = btn_reset;
      if (reset) begin
         for (int b = 0; b < 3; b++) begin
            m_p1[b] = 0; m_p2[b] = 0; m_acc[b] = 0; m_ev[b] = 0; m_run[b] = 0;
         end
         m_state = 0; m_elapsed = 0;
         m_tick = 0; m_clear = 0; m_freeze = 0;
      end else begin
         nxt = m_state;
         m_clear = 0;
         if (m_ev[2]) begin
            nxt = 0;
            m_clear = 1;
         end else if (m_ev[0]) begin
            nxt = (m_state == 1 || m_state == 3) ? 2 : 1;
         end else if (m_ev[1]) begin
            if (m_state == 1) nxt = 3;
            else if (m_state == 3) nxt = 1;
         end
         running_now  = (m_state == 1 || m_state == 3);
         running_next = (nxt == 1 || nxt == 3);
         m_tick = 0;
         if (nxt == 0) begin
            m_elapsed = 0;
         end else if (running_now && running_next) begin
            m_elapsed++;
            if (m_elapsed == TD) begin
               m_tick = 1;
               m_elapsed = 0;
            end
         end
         m_state  = nxt;
         m_freeze = (nxt == 3);
         for (int b = 0; b < 3; b++) begin
            samp = m_p2[b];
            m_p2[b] = m_p1[b];
            m_p1[b] = raw[b];
            m_ev[b] = 0;
            if (samp != m_acc[b]) begin
               m_run[b]++;
               if (m_run[b] == DB) begin
                  m_acc[b] = samp;
                  m_run[b] = 0;
                  m_ev[b]  = samp;
               end
            end else begin
               m_run[b] = 0;
            end
         end
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      chk("state",  int'(state),  m_state);
      chk("tick",   int'(tick),   int'(m_tick));
      chk("clear",  int'(clear),  int'(m_clear));
      chk("freeze", int'(freeze), int'(m_freeze));
   endtask

   task automatic wait_state(input int exp, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (int'(state) != exp && n < 60);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (tick !== 1'b1 && n < 60);
   endtask

   initial begin
      int n;
      int ticks;
      bit visited;
      int hold[3];
      bit lvl_r[3];

      reset = 1'b1; btn_startstop = 1'b0; btn_lap = 1'b0; btn_reset = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;

      // idle
      repeat (50) cyc();
      chk("idle_state", int'(state), 0);

      // start: 2 sync + 4 debounce + 1 FSM edge
      btn_startstop = 1'b1;
      wait_state(1, n);
      chk("start_latency", n, 7);
      wait_tick(n);
      chk("first_tick", n, 10);
      wait_tick(n);
      chk("tick_period", n, 10);
      btn_startstop = 1'b0;
      wait_tick(n);
      chk("tick_period2", n, 10);

      // press right on a tick so the pause lands with the prescaler at 6
      btn_startstop = 1'b1;
      wait_state(2, n);
      chk("pause_latency", n, 7);
      btn_startstop = 1'b0;
      ticks = 0;
      repeat (100) begin
         cyc();
         ticks += int'(tick);
      end
      chk("pause_ticks", ticks, 0);
      chk("pause_state", int'(state), 2);
      btn_startstop = 1'b1;
      wait_state(1, n);
      chk("resume_latency", n, 7);
      wait_tick(n);
      chk("resume_tick", n, 4);
      btn_startstop = 1'b0;
      repeat (10) cyc();

      // lap hold
      btn_lap = 1'b1;
      wait_state(3, n);
      chk("lap_latency", n, 7);
      chk("lap_freeze", int'(freeze), 1);
      btn_lap = 1'b0;
      ticks = 0;
      repeat (30) begin
         cyc();
         ticks += int'(tick);
      end
      chk("lap_ticks", ticks, 3);
      chk("lap_state", int'(state), 3);
      btn_lap = 1'b1;
      wait_state(1, n);
      chk("unlap_latency", n, 7);
      chk("unlap_freeze", int'(freeze), 0);
      btn_lap = 1'b0;
      repeat (10) cyc();

      // all three at once in RUN: reset wins
      btn_startstop = 1'b1; btn_lap = 1'b1; btn_reset = 1'b1;
      n = 0; visited = 0;
      do begin
         cyc();
         n++;
         if (state == 2'd2 || state == 2'd3) visited = 1;
      end while (state != 2'd0 && n < 60);
      chk("all3_latency", n, 7);
      chk("all3_clear", int'(clear), 1);
      chk("all3_no_pause_lap", int'(visited), 0);
      btn_startstop = 1'b0; btn_lap = 1'b0; btn_reset = 1'b0;
      cyc();
      chk("clear_width", int'(clear), 0);
      repeat (10) cyc();

      // bounce of 1..3 samples is rejected
      for (int k = 1; k <= 3; k++) begin
         btn_startstop = 1'b1;
         repeat (k) cyc();
         btn_startstop = 1'b0;
         repeat (10) cyc();
         chk($sformatf("bounce_%0d", k), int'(state), 0);
      end

      // reset mid-debounce, then a 2-sample glitch
      btn_startstop = 1'b1;
      repeat (4) cyc();
      btn_startstop = 1'b0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      btn_startstop = 1'b1;
      repeat (2) cyc();
      btn_startstop = 1'b0;
      repeat (10) cyc();
      chk("glitch_after_reset", int'(state), 0);

      // button held through reset release counts as one press
      btn_startstop = 1'b1;
      reset = 1'b1;
      repeat (3) cyc();
      reset = 1'b0;
      wait_state(1, n);
      chk("held_through_reset", n, 7);
      repeat (5) cyc();
      reset = 1'b1;
      cyc();
      chk("reset_mid_run", int'(state), 0);
      chk("reset_mid_run_tick", int'(tick), 0);
      reset = 1'b0;
      btn_startstop = 1'b0;
      repeat (10) cyc();

      // randomized button activity with occasional resets
      for (int b = 0; b < 3; b++) begin
         hold[b] = 0;
         lvl_r[b] = 0;
      end
      repeat (3000) begin
         for (int b = 0; b < 3; b++) begin
            if (hold[b] == 0) begin
               lvl_r[b] = 1'($urandom_range(0, 1));
               hold[b]  = int'($urandom_range(1, 14));
            end
            hold[b]--;
         end
         btn_startstop = lvl_r[0];
         btn_lap       = lvl_r[1];
         btn_reset     = (lvl_r[2] && $urandom_range(0, 3) != 0) ? 1'b1 : lvl_r[2];
         reset         = ($urandom_range(0, 299) == 0);
         cyc();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch datapath on the Nexys A7. It synchronizes and debounces the start/stop, lap and reset push-buttons and runs the RUN/PAUSE/LAP/IDLE state machine. It produces the gated 100 Hz count tick, a clear pulse for the time counter, and a display-freeze flag for lap hold. The downstream BCD time counter increments only on `tick`, zeroes only on `clear`, and the display latch holds while `freeze` is high.

## Interface
- `TICK_DIV`, default 1000000: clk cycles per tick (100 MHz → 100 Hz); ≥2.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive identical synchronized samples needed to accept a level change (10 ms); ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_startstop`  in  1  raw asynchronous button, high = pressed.
- `btn_lap`  in  1  raw asynchronous button, high = pressed.
- `btn_reset`  in  1  raw asynchronous button, high = pressed.
- `tick`  out  1  one-cycle count-enable pulse, only in RUN or LAP.
- `clear`  out  1  one-cycle pulse commanding the time counter to zero.
- `freeze`  out  1  high while in LAP.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, LAP=3.

## Operation
- Per button: 2-flop synchronizer → debouncer → rising-edge detector.
- Debouncer: holds accepted level `lvl` (reset 0) and counter `cnt`.
  - Synchronized sample == `lvl`: `cnt` ← 0.
  - Otherwise `cnt` increments. When it reaches DEBOUNCE_CYCLES−1, `lvl` flips and `cnt` ← 0.
  - `press` = one-cycle pulse on `lvl` 0→1. Releases generate no event.
- Event priority on the same cycle: reset press > startstop press > lap press. Lower-priority presses that cycle are discarded.
- FSM transitions:
  - IDLE: startstop → RUN; reset → IDLE with `clear`; lap ignored.
  - RUN: startstop → PAUSE; lap → LAP; reset → IDLE with `clear`.
  - LAP: lap → RUN; startstop → PAUSE (`freeze` drops); reset → IDLE with `clear`.
  - PAUSE: startstop → RUN; lap ignored; reset → IDLE with `clear`.
- Prescaler `div`, width $clog2(TICK_DIV):
  - RUN/LAP: counts 0..TICK_DIV−1. `tick` = 1 in the cycle `div` == TICK_DIV−1, then `div` wraps to 0.
  - PAUSE: `div` holds its value, so the fractional 10 ms is preserved across pause/resume.
  - IDLE: `div` forced to 0.
- Ticks continue in LAP; only the display is frozen.

## Timing
- All outputs are registered.
- Reset values: `tick`=0, `clear`=0, `freeze`=0, `state`=IDLE; all `lvl`, `cnt` and `div` = 0, synchronizer flops = 0.
- Reset is honoured on any cycle, including mid-debounce and mid-tick period. Everything returns to reset values the next edge.
- Press latency: raw rising edge → `press` pulse takes 2 (sync) + DEBOUNCE_CYCLES cycles for a clean edge. `state`/`freeze`/`clear` update on the edge after `press`.
- `clear` is high exactly one cycle, coincident with `state` becoming IDLE, for every accepted reset press, including one accepted while already in IDLE.
- First `tick` after entering RUN from IDLE arrives TICK_DIV cycles after the cycle `state` first reads RUN.
- `tick` never asserts in a cycle where `state` reads IDLE or PAUSE.
  - If the transition to PAUSE/IDLE and `div` == TICK_DIV−1 coincide, the state change wins and no tick is issued.
- Bounce shorter than DEBOUNCE_CYCLES samples is rejected entirely. A button held through release of `reset` is accepted as one press after debounce.
- Holding a button produces exactly one event; a new event needs a release to be accepted first.

## Test plan
Bench parameters: TICK_DIV=10, DEBOUNCE_CYCLES=4.
- Reset then idle for 50 cycles → `state`=0, `tick`/`clear`/`freeze` stay 0.
- Clean startstop press held for 20 cycles → exactly one transition to RUN. Ticks every 10 cycles, first tick 10 cycles after RUN. A second press → PAUSE, with no ticks for 100 cycles.
- Pause when `div`=6, resume → first tick 4 cycles after `state` returns to RUN.
- In RUN, lap press → `state`=3, `freeze`=1, ticks continue. Second lap press → `state`=1, `freeze`=0.
- Startstop, lap and reset pressed in the same cycle while in RUN → `state`=0, one-cycle `clear`, no PAUSE/LAP visited.
- Startstop pulses of 1–3 samples (bounce) → no state change. Assert `reset` mid-debounce → counters clear and a following 2-sample glitch is also rejected.
